// File: rtl/regfile_ctl.sv
// Command sequencer between the byte-serial host link and the frequency-meter
// config register file: decodes commands, assembles config writes, streams read-back.
module regfile_ctl #(
  parameter logic [7:0]  CMD_CONF_WR = 8'h2A,
  parameter logic [7:0]  CMD_CONF_RD = 8'h3A,
  parameter int unsigned WR_BYTES    = 8,
  parameter int unsigned RD_BYTES    = 16,
  localparam int unsigned WR_W       = WR_BYTES * 8,
  localparam int unsigned ADDR_W     = $clog2(RD_BYTES)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rx_vld_i,
  input  logic [7:0]        rx_data_i,
  input  logic              frame_end_i,
  input  logic              tx_req_i,
  output logic [7:0]        tx_data_o,
  output logic              reg_rd_en_o,
  output logic [ADDR_W-1:0] reg_rd_addr_o,
  input  logic [7:0]        reg_rd_data_i,
  output logic              reg_wr_en_o,
  output logic [WR_W-1:0]   reg_wr_data_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(WR_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [7:0]         tx_d;
  logic               rd_en_d;
  logic               wr_en_d;
  logic [WR_W-1:0]    wr_data_d;
  logic               busy_d;
  logic               err_d;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_data_o     <= '0;
      reg_rd_en_o   <= 1'b0;
      reg_rd_addr_o <= '0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_data_o <= '0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_data_o     <= tx_d;
      reg_rd_en_o   <= rd_en_d;
      reg_rd_addr_o <= addr_d;
      reg_wr_en_o   <= wr_en_d;
      reg_wr_data_o <= wr_data_d;
      busy_o        <= busy_d;
      err_o         <= err_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = reg_rd_addr_o;
    wr_data_d = reg_wr_data_o;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_vld_i) begin
          if (rx_data_i == CMD_CONF_WR) begin
            state_d = WR_DATA;
            cnt_d   = '0;
          end else if (rx_data_i == CMD_CONF_RD) begin
            state_d = RD_DATA;
            addr_d  = '0;
          end else begin
            state_d = DROP;
            err_d   = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (rx_vld_i) begin
          for (int i = 0; i < int'(WR_BYTES); i++) begin
            if (cnt_q == CNT_W'(i)) wr_data_d[8*i +: 8] = rx_data_i;
          end
          if (cnt_q == CNT_W'(WR_BYTES - 1)) begin
            wr_en_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RD_DATA: begin
        // Final request ends the burst without wrapping the address
        if (tx_req_i) begin
          if (reg_rd_addr_o == ADDR_W'(RD_BYTES - 1)) state_d = IDLE;
          else addr_d = reg_rd_addr_o + ADDR_W'(1);
        end
      end
      DROP: ;
      default: state_d = IDLE;
    endcase

    // Chip-select release aborts everything; a write completing this cycle still strobes
    if (frame_end_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      addr_d  = '0;
      err_d   = 1'b0;
    end

    rd_en_d = (state_d == RD_DATA);
    busy_d  = (state_d != IDLE);
    tx_d    = (state_q == RD_DATA) ? reg_rd_data_i : 8'h00;
  end

endmodule

// File: tb/tb_regfile_ctl.sv
// Self-checking bench for regfile_ctl: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_regfile_ctl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        rx_vld_i;
  logic [7:0]  rx_data_i;
  logic        frame_end_i;
  logic        tx_req_i;
  logic [7:0]  tx_data_o;
  logic        reg_rd_en_o;
  logic [3:0]  reg_rd_addr_o;
  logic [7:0]  reg_rd_data_i;
  logic        reg_wr_en_o;
  logic [63:0] reg_wr_data_o;
  logic        busy_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  regfile_ctl dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .rx_vld_i      (rx_vld_i),
    .rx_data_i     (rx_data_i),
    .frame_end_i   (frame_end_i),
    .tx_req_i      (tx_req_i),
    .tx_data_o     (tx_data_o),
    .reg_rd_en_o   (reg_rd_en_o),
    .reg_rd_addr_o (reg_rd_addr_o),
    .reg_rd_data_i (reg_rd_data_i),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_data_o (reg_wr_data_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  // Register file: 16-byte read window, config write lands in bytes 8..15
  logic [7:0] mem [16];
  assign reg_rd_data_i = mem[reg_rd_addr_o];

  int n_cmp = 0;
  int n_mis = 0;
  int since_req = 100;

  // Transaction-level model
  bit          wr_act, rd_act, drop_act;
  logic [7:0]  wr_q[$];
  int          m_addr;
  logic [63:0] m_data;
  bit          m_wr_en, m_err;
  logic [7:0]  m_tx;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_act = 0; rd_act = 0; drop_act = 0;
    wr_q.delete();
    m_addr = 0; m_data = '0; m_wr_en = 0; m_err = 0; m_tx = '0;
  endtask

  task automatic check_all(input string pfx);
    check_eq({pfx, "_tx"},    64'(tx_data_o),     64'(m_tx));
    check_eq({pfx, "_rden"},  64'(reg_rd_en_o),   64'(rd_act));
    check_eq({pfx, "_addr"},  64'(reg_rd_addr_o), 64'(m_addr));
    check_eq({pfx, "_wren"},  64'(reg_wr_en_o),   64'(m_wr_en));
    check_eq({pfx, "_wdata"}, reg_wr_data_o,      m_data);
    check_eq({pfx, "_busy"},  64'(busy_o),        64'(wr_act || rd_act || drop_act));
    check_eq({pfx, "_err"},   64'(err_o),         64'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic v, input logic [7:0] b, input logic fe, input logic rq);
    bit idle0;
    rx_vld_i = v; rx_data_i = b; frame_end_i = fe; tx_req_i = rq;
    since_req = rq ? 0 : since_req + 1;
    idle0 = !(wr_act || rd_act || drop_act);
    m_tx = rd_act ? mem[m_addr] : 8'h00;
    m_wr_en = 0; m_err = 0;
    if (wr_act && v) begin
      m_data[8*wr_q.size() +: 8] = b;
      wr_q.push_back(b);
      if (wr_q.size() == 8) begin
        m_wr_en = 1;
        wr_act = 0;
      end
    end
    if (rd_act && rq) begin
      if (m_addr == 15) rd_act = 0;
      else m_addr++;
    end
    if (fe) begin
      wr_act = 0; rd_act = 0; drop_act = 0; m_addr = 0;
    end else if (idle0 && v) begin
      if (b == 8'h2A) begin
        wr_act = 1; wr_q.delete();
      end else if (b == 8'h3A) begin
        rd_act = 1; m_addr = 0;
      end else begin
        drop_act = 1; m_err = 1;
      end
    end
    @(posedge clk_i);
    #1;
    if (reg_wr_en_o) for (int i = 0; i < 8; i++) mem[8+i] = reg_wr_data_o[8*i +: 8];
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
    idle($urandom_range(0, 1));
  endtask

  task automatic read_burst();
    send(8'h3A);
    for (int k = 0; k < 16; k++) begin
      idle(2);
      check_eq("rd_byte", 64'(tx_data_o), 64'(mem[k]));
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    idle(2);
  endtask

  task automatic frame_end();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
  endtask

  initial begin
    logic [63:0] old_cfg;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    rst_n_i = 1'b0; rx_vld_i = 0; rx_data_i = 0; frame_end_i = 0; tx_req_i = 0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_all("rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle(2);

    // Plain write
    send(8'h2A);
    for (int i = 1; i <= 8; i++) send(8'(i));
    idle(1);
    check_eq("t1_data", reg_wr_data_o, 64'h0807060504030201);
    check_eq("t1_mem8", 64'(mem[8]), 64'h01);

    // Full read burst
    read_burst();
    check_eq("t2_rden_off", 64'(reg_rd_en_o), 64'h0);
    frame_end();

    // Aborted write
    old_cfg = {mem[15], mem[14], mem[13], mem[12], mem[11], mem[10], mem[9], mem[8]};
    send(8'h2A); send(8'h11); send(8'h22); send(8'h33);
    frame_end();
    check_eq("t3_busy", 64'(busy_o), 64'h0);
    read_burst();
    check_eq("t3_cfg_kept", {mem[15], mem[14], mem[13], mem[12], mem[11], mem[10], mem[9], mem[8]}, old_cfg);
    frame_end();

    // Unknown command drops the rest of the frame
    send(8'h55);
    send(8'h2A);
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i));
    check_eq("t4_busy", 64'(busy_o), 64'h1);
    frame_end();

    // frame_end together with the final write byte
    send(8'h2A);
    for (int i = 0; i < 7; i++) send(8'h70 + 8'(i));
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check_eq("t5_wren", 64'(reg_wr_en_o), 64'h1);
    check_eq("t5_data", reg_wr_data_o, 64'hA576757473727170);
    idle(2);

    // Write then read in the same frame
    send(8'h2A);
    for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i));
    read_burst();
    check_eq("t6_mem15", 64'(mem[15]), 64'hE7);
    frame_end();

    // Async reset in the middle of a write
    send(8'h2A); send(8'h9A); send(8'h9B);
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic v, fe, rq;
      logic [7:0] b;
      int sel;
      v   = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 3);
      b   = (sel == 0) ? 8'h2A : (sel == 1) ? 8'h3A : 8'($urandom);
      fe  = !v && ($urandom_range(0, 39) == 0);
      rq  = (since_req >= 2) && ($urandom_range(0, 1) == 0);
      step(v, b, fe, rq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
